uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- 8N1 UART serializer; the transmit counterpart of uart_receiver, with the same parameter names and baud arithmetic.
- Accepts one byte per valid/ready handshake from on-chip logic and drives the serial txd pin.
- Sits at the FPGA top level next to uart_receiver, which closes the loopback for the debug console.

Parameters:
- clk_freq, 12000000, system clock frequency in Hz.
- baud_rate, 115200, line rate in bit/s.
- parity_odd, 0, parity sense (0 = even, 1 = odd); only used when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- data  input  8  byte to send; sampled only on the accept cycle.
- valid  input  1  requester has a byte on data.
- ready  output  1  high only in IDLE; a byte is accepted on a rising clk edge where valid && ready.
- txd  output  1  serial line, idle high; registered output.
- done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Divider: DIV = clk_freq / baud_rate, integer truncation; DIV >= 2 is required.
- Baud counter width: clog2(DIV).
- Reset (rst = 0, asynchronous):
  - state = IDLE, txd = 1, ready = 1, done = 0.
  - Baud counter, bit index and shift register clear.
  - A frame in progress is aborted; txd returns high immediately, without waiting for clk.
- Clocking after reset: release is synchronized internally; first accept is possible on the 2nd clk edge after rst rises.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - txd = 1, ready = 1.
  - On valid && ready, latch data into the shift register and go to START.
- START: txd = 0 for exactly DIV cycles, beginning the cycle after the accept edge.
- DATA:
  - 8 bits, LSB first, each held exactly DIV cycles.
  - Shift right at each bit boundary; the bit index counts 0..7.
- STOP:
  - txd = 1 for DIV cycles.
  - done = 1 on the last of those cycles; next state IDLE.
- Frame length: start-bit falling edge to IDLE entry = 10*DIV cycles (8N1).
- Back-to-back frames:
  - If valid stays high, the next accept happens on the first IDLE cycle.
  - The effective stop bit is therefore DIV+1 cycles; this is the minimum inter-frame gap.
- ready is 0 from the cycle after accept through the last STOP cycle.
- While ready = 0:
  - valid is ignored and never queued.
  - Changes on data have no effect; the latched byte is sent unchanged.
- txd never glitches: it changes only on bit boundaries and is driven directly from a flop.
- done and ready = 1 are never high in the same cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - txd = ^byte XOR parity_odd.
  - Frame = 11*DIV cycles.
- When undefined:
  - No PARITY state or logic is present; parity_odd is ignored.
  - Frame = 10*DIV cycles.

Test Plan (clk_freq = 8, baud_rate = 1, so DIV = 8, unless noted):
- Reset and idle:
  - Stimulus: hold rst = 0 for 3 cycles, then release with valid = 0.
  - Response: txd = 1, ready = 1, done = 0 throughout; no transitions on txd for 100 cycles.
- Single byte 0x55:
  - Stimulus: pulse valid with data = 0x55.
  - Response: txd = 0 for 8 cycles, then 1,0,1,0,1,0,1,0 each for 8 cycles, then stop = 1 for 8 cycles.
  - done pulses at cycle 80 after accept; ready returns high at cycle 81.
- Back-to-back with data change:
  - Stimulus: valid held high; data = 0xA3, then 0x0F presented on the cycle after the first accept.
  - Response: first frame carries 0xA3 (bits 1,1,0,0,0,1,0,1), and the data change does not corrupt it.
  - Second start bit falls exactly 81 cycles after the first one.
- Busy rejection:
  - Stimulus: accept 0x00; pulse valid with data = 0xFF at cycle 30.
  - Response: 0x00 frame completes unchanged; the 0xFF request is not sent and no second frame appears.
- Reset mid-frame:
  - Stimulus: send 0x81; assert rst = 0 during data bit 3, asynchronously between clk edges.
  - Response: txd = 1 before the next clk edge; after release, ready = 1 and a fresh 0x42 sends correctly.
- Parity build (UART_TX_PARITY_EN defined):
  - Stimulus: send 0x07 with parity_odd = 0, then again with parity_odd = 1.
  - Response: parity bit = 1 then 0; frame length 88 cycles to done.
  - Also run the loopback of txd into uart_receiver (no parity) for 0x00..0xFF and check every received byte matches.

Source files
------------

// File: rtl/uart_transmitter.sv
//------------------------------------------------------------------------------
// uart_transmitter
//   8N1 UART serializer with a valid/ready byte interface and a registered,
//   idle-high txd pin. Bit period DIV = clk_freq / baud_rate (DIV >= 2).
//   Reset (rst) is asynchronous, active-low; its release is synchronized
//   internally so the first accept can happen on the 2nd clk edge after
//   rst rises.
//   Optional feature: define UART_TX_PARITY_EN to insert a parity bit
//   (^byte XOR parity_odd) between the last data bit and the stop bit.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_transmitter #(
    parameter int clk_freq   = 12000000,
    parameter int baud_rate  = 115200,
    parameter bit parity_odd = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       done
);

    localparam int DIV   = clk_freq / baud_rate;
    localparam int CNT_W = $clog2(DIV);

    // Last cycle of a bit period, and the cycle before it (for the done pulse).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic             r_rst_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             r_ready;
    logic             r_done;
    logic             w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`else
    // parity_odd has no function without the parity bit; tie it off here.
    logic             w_unused_parity;
    assign w_unused_parity = parity_odd;
`endif

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Reset release synchronizer: assertion passes straight through (txd goes
    // high without a clock), release is retimed to clk.
    // NOTE: async assertion / sync release keeps every state flop leaving
    // reset on the same edge, so the FSM cannot start in a torn state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
        end
    end

    // Frame sequencer: state, baud counter, bit index, shift register and all
    // registered outputs advance together.
    // NOTE: non-blocking assignments throughout, so every branch reads the
    // pre-edge values (e.g. r_shift[1] below is the bit about to shift into [0]).
    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd     <= 1'b1;
                    r_ready   <= 1'b1;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (valid && r_ready) begin
                        r_shift <= data;
                        r_txd   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^data) ^ parity_odd;
`endif
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_txd     <= r_parity;
                            r_state   <= S_PARITY;
`else
                            r_txd     <= 1'b1;
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Registered pulse lands on the final stop-bit cycle.
                        if (r_cnt == CNT_PRE) begin
                            r_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_txd   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign txd   = r_txd;
    assign ready = r_ready;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
//------------------------------------------------------------------------------
// tb_uart_transmitter
//   Directed bench for uart_transmitter at DIV = 8. A frame-timeline model
//   (cycles since accept -> expected line bit) is compared against txd, ready
//   and done on every falling clk edge; directed sequences add literal
//   expectations for captured frames and timing.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_transmitter;

    localparam int CLK_FREQ   = 8;
    localparam int BAUD       = 1;
    localparam int DIV        = 8;
    localparam bit PARITY_ODD = 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP_55 = 11'h4AA;
    localparam logic [10:0] EXP_A3 = 11'h546;
    localparam logic [10:0] EXP_0F = 11'h41E;
    localparam logic [10:0] EXP_00 = 11'h400;
    localparam logic [10:0] EXP_42 = 11'h484;
    localparam int DONE_AT  = 88;
    localparam int READY_AT = 89;
    localparam int GAP      = 89;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_55 = 11'h2AA;
    localparam logic [10:0] EXP_A3 = 11'h346;
    localparam logic [10:0] EXP_0F = 11'h21E;
    localparam logic [10:0] EXP_00 = 11'h200;
    localparam logic [10:0] EXP_42 = 11'h284;
    localparam int DONE_AT  = 80;
    localparam int READY_AT = 81;
    localparam int GAP      = 81;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       txd;
    logic       done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    uart_transmitter #(
        .clk_freq   (CLK_FREQ),
        .baud_rate  (BAUD),
        .parity_odd (PARITY_ODD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .txd   (txd),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line bit idx (0 = start) of the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return (^b) ^ PARITY_ODD;
`endif
        return 1'b1;
    endfunction

    function automatic logic [10:0] exp_cap(input logic [7:0] b);
        logic [10:0] r = '0;
        for (int k = 0; k < NB; k++) r[k] = frame_bit(b, k);
        return r;
    endfunction

    // Timeline model: m_t = cycles since the accept edge (1..FRAME).
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;
    int         m_edges  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_edges  <= 0;
        end else begin
            if (m_active) begin
                if (m_t == FRAME) m_active <= 1'b0;
                else              m_t <= m_t + 1;
            end else if (m_edges >= 1 && valid) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_byte   <= data;
            end
            if (m_edges < 2) m_edges <= m_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd_vs_model",   txd,   m_active ? frame_bit(m_byte, (m_t - 1) / DIV) : 1'b1);
            check("ready_vs_model", ready, !m_active);
            check("done_vs_model",  done,  m_active && (m_t == FRAME));
        end
    end

    // Per-frame stimulus knobs and capture results.
    bit          hold_valid = 1'b0;
    logic [7:0]  next_data  = 8'h00;
    int          pulse_at   = 0;
    int          rst_at     = 0;
    logic        samp [0:127];
    int          done_at, ready_at, fall_at;
    logic [10:0] cap;

    // Called on a falling edge. Optionally presents b with valid, waits for
    // the accept edge, then records FRAME+1 cycles of line activity.
    task automatic run_frame(input bit drive, input logic [7:0] b);
        done_at  = 0;
        ready_at = 0;
        fall_at  = 0;
        if (drive) begin
            data  = b;
            valid = 1'b1;
        end
        @(posedge clk);
        for (int n = 1; n <= FRAME + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                data = next_data;
                if (!hold_valid) valid = 1'b0;
            end
            if (pulse_at != 0 && n == pulse_at) begin
                valid = 1'b1;
                data  = 8'hFF;
            end
            if (pulse_at != 0 && n == pulse_at + 1) valid = 1'b0;
            samp[n] = txd;
            if (done  === 1'b1 && done_at  == 0) done_at  = n;
            if (ready === 1'b1 && ready_at == 0) ready_at = n;
            if (txd   === 1'b0 && fall_at  == 0) fall_at  = n;
            if (n == rst_at) begin
                check("txd_before_async_rst", txd, 1'b0);
                #2 rst = 1'b0;
                #1 check("txd_async_rst_high", txd, 1'b1);
                break;
            end
        end
        cap = '0;
        for (int k = 0; k < NB; k++) cap[k] = samp[k * DIV + DIV / 2 + 1];
    endtask

    initial begin
        int trans;
        int lows;
        int f1;
        logic prev;

        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_txd",   txd,   1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_done",  done,  1'b0);
        rst   = 1'b1;
        trans = 0;
        prev  = txd;
        repeat (100) begin
            @(negedge clk);
            if (txd !== prev) trans++;
            prev = txd;
        end
        check("idle_txd_transitions", trans, 0);
        check("idle_ready", ready, 1'b1);

        // Single byte 0x55
        hold_valid = 1'b0; next_data = 8'h55; pulse_at = 0; rst_at = 0;
        run_frame(1'b1, 8'h55);
        check("frame_55",    cap,      EXP_55);
        check("done_cycle",  done_at,  DONE_AT);
        check("ready_cycle", ready_at, READY_AT);
        check("start_cycle", fall_at,  1);

        // Back-to-back with a data change after the first accept
        hold_valid = 1'b1; next_data = 8'h0F;
        run_frame(1'b1, 8'hA3);
        f1 = fall_at;
        check("frame_a3", cap, EXP_A3);
        hold_valid = 1'b0;
        run_frame(1'b0, 8'h0F);
        check("frame_0f", cap, EXP_0F);
        check("b2b_start_gap", (FRAME + 1) + fall_at - f1, GAP);

        // Busy rejection
        next_data = 8'h00; pulse_at = 30;
        run_frame(1'b1, 8'h00);
        pulse_at = 0;
        check("frame_00_busy", cap, EXP_00);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("no_second_frame", lows, 0);

        // Reset mid-frame during data bit 3, then a fresh byte
        next_data = 8'h81; rst_at = 36;
        run_frame(1'b1, 8'h81);
        rst_at = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_txd",   txd,   1'b1);
        next_data = 8'h42;
        run_frame(1'b1, 8'h42);
        check("frame_42", cap, EXP_42);

`ifdef UART_TX_PARITY_EN
        next_data = 8'h07;
        run_frame(1'b1, 8'h07);
        check("parity_07_bit",   cap[9],  1'b1);
        check("parity_07_frame", cap,     11'h60E);
        check("parity_07_done",  done_at, 88);
`endif

        // Every byte value through the line decoder
        for (int b = 0; b < 256; b++) begin
            next_data = 8'(b);
            run_frame(1'b1, 8'(b));
            check("sweep_frame", cap, exp_cap(8'(b)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
